pipe_stage_reg: RTL and testbench

Parametrised pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a data field, a control field and a valid bit through DEPTH register slots, and adds controls that a fixed single-stage register does not have. Stall-bubble inserts a NOP on control. Hold freezes the whole register. Flush kills every in-flight slot. Two saturating event counters support stall/flush accounting. The hazard unit drives the control inputs; downstream stages consume the outputs.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_slot.sv | 50 +++++
 rtl/pipe_stage_reg.sv | 84 ++++++++
 tb/tb_pipe_stage_reg.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: packed control fields per stage and their NOP encodings.
// Stages instantiate pipe_stage_reg with CTRL_W = $bits of the fields they carry.
package pipe_pkg;

  typedef struct packed {
    logic [3:0] alu_ctr;
    logic       alu_src;
    logic       reg_dst;
    logic       ext_op;
    logic       branch;
  } ex_ctrl_t;

  typedef struct packed {
    logic       mem_wr;
    logic       mem_read;
    logic [1:0] mem_size;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_wr;
    logic mem_to_reg;
    logic link;
    logic sign_ext;
  } wb_ctrl_t;

  localparam int EX_CTRL_W  = $bits(ex_ctrl_t);
  localparam int MEM_CTRL_W = $bits(mem_ctrl_t);
  localparam int WB_CTRL_W  = $bits(wb_ctrl_t);

  // ID/EX carries all three groups; later boundaries carry a suffix of them.
  localparam int ID_EX_CTRL_W  = EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;
  localparam int EX_MEM_CTRL_W = MEM_CTRL_W + WB_CTRL_W;
  localparam int MEM_WB_CTRL_W = WB_CTRL_W;

  localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_CTRL_NOP  = '0;
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_CTRL_NOP = '0;
  localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register slot: data, control and valid with kill/hold/nop/load,
// in that priority order below reset. Updates on the falling clock edge.
module pipe_slot #(
  parameter int                 DATA_W   = 96,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              hold,
  input  logic              nop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out
);

  logic [DATA_W-1:0] data_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic              valid_reg;

  // Kill and nop both leave the data field untouched; only reset clears it.
  always_ff @(negedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      ctrl_reg  <= CTRL_NOP;
      valid_reg <= 1'b0;
    end else if (kill) begin
      ctrl_reg  <= CTRL_NOP;
      valid_reg <= 1'b0;
    end else if (!hold) begin
      if (nop) begin
        ctrl_reg  <= CTRL_NOP;
        valid_reg <= 1'b0;
      end else begin
        data_reg  <= data_in;
        ctrl_reg  <= ctrl_in;
        valid_reg <= valid_in;
      end
    end
  end

  assign data_out  = data_reg;
  assign ctrl_out  = ctrl_reg;
  assign valid_out = valid_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Multi-slot inter-stage pipeline register with bubble, hold and flush controls
// plus saturating bubble/flush event counters. State changes on the falling edge.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 96,
  parameter int                 CTRL_W   = ID_EX_CTRL_W,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
  parameter int                 DEPTH    = 1,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              valid_i,
  input  logic              bubble_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic [DATA_W-1:0] data_chain  [DEPTH+1];
  logic [CTRL_W-1:0] ctrl_chain  [DEPTH+1];
  logic              valid_chain [DEPTH+1];

  logic             hold_eff;
  logic             bubble_eff;
  logic [CNT_W-1:0] bubble_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // A masked request does nothing, so it must not be counted either.
  assign hold_eff   = hold_i & ~flush_i;
  assign bubble_eff = bubble_i & ~hold_i & ~flush_i;

  assign data_chain[0]  = data_i;
  assign ctrl_chain[0]  = ctrl_i;
  assign valid_chain[0] = valid_i;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      pipe_slot #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_NOP (CTRL_NOP)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .kill      (flush_i),
        .hold      (hold_eff),
        .nop       ((gi == 0) ? bubble_eff : 1'b0),
        .data_in   (data_chain[gi]),
        .ctrl_in   (ctrl_chain[gi]),
        .valid_in  (valid_chain[gi]),
        .data_out  (data_chain[gi+1]),
        .ctrl_out  (ctrl_chain[gi+1]),
        .valid_out (valid_chain[gi+1])
      );
    end
  endgenerate

  always_ff @(negedge clk) begin
    if (rst) begin
      bubble_cnt_reg <= '0;
      flush_cnt_reg  <= '0;
    end else begin
      if (flush_i && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      if (bubble_eff && (bubble_cnt_reg != '1))
        bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
    end
  end

  assign data_o       = data_chain[DEPTH];
  assign ctrl_o       = ctrl_chain[DEPTH];
  assign valid_o      = valid_chain[DEPTH];
  assign bubble_cnt_o = bubble_cnt_reg;
  assign flush_cnt_o  = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench: a DEPTH=1 instance with 2-bit counters and a
// DEPTH=3 instance with a non-zero NOP encoding, sharing one stimulus bus.
module tb_pipe_stage_reg;

  localparam int DW = 96;
  localparam int CW = 16;
  localparam logic [CW-1:0] NOP3 = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst, flush, hold, bubble, valid;
  logic [DW-1:0] data;
  logic [CW-1:0] ctrl;

  logic [DW-1:0] d1_data, d3_data;
  logic [CW-1:0] d1_ctrl, d3_ctrl;
  logic          d1_valid, d3_valid;
  logic [1:0]    d1_bcnt, d1_fcnt;
  logic [15:0]   d3_bcnt, d3_fcnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(16'h0000), .DEPTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .data_i(data), .ctrl_i(ctrl), .valid_i(valid),
    .bubble_i(bubble), .hold_i(hold), .flush_i(flush),
    .data_o(d1_data), .ctrl_o(d1_ctrl), .valid_o(d1_valid),
    .bubble_cnt_o(d1_bcnt), .flush_cnt_o(d1_fcnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP3), .DEPTH(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .data_i(data), .ctrl_i(ctrl), .valid_i(valid),
    .bubble_i(bubble), .hold_i(hold), .flush_i(flush),
    .data_o(d3_data), .ctrl_o(d3_ctrl), .valid_o(d3_valid),
    .bubble_cnt_o(d3_bcnt), .flush_cnt_o(d3_fcnt)
  );

  typedef struct {
    logic          rst, flush, hold, bubble, valid;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic [15:0]   eb, ef;
  } vec_t;

  vec_t tab1[$];
  vec_t tab3[$];

  function automatic vec_t mk(logic r, logic f, logic h, logic b, logic v,
                              logic [DW-1:0] d, logic [CW-1:0] c,
                              logic ev, logic [DW-1:0] ed, logic [CW-1:0] ec,
                              logic [15:0] eb, logic [15:0] ef);
    vec_t t;
    t.rst = r; t.flush = f; t.hold = h; t.bubble = b; t.valid = v;
    t.data = d; t.ctrl = c; t.ev = ev; t.ed = ed; t.ec = ec; t.eb = eb; t.ef = ef;
    return t;
  endfunction

  task automatic chk(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic apply(vec_t t);
    rst = t.rst; flush = t.flush; hold = t.hold; bubble = t.bubble;
    valid = t.valid; data = t.data; ctrl = t.ctrl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0; bubble = 1'b0; valid = 1'b0;
    data = '0; ctrl = '0;

    // DEPTH=1, CNT_W=2: reset, load-use bubble, hold vs bubble, flush, saturation
    tab1.push_back(mk(1,1,1,1,1, 96'hBAD, 16'h1234, 0, 96'h0,  16'h0000, 0, 0));
    tab1.push_back(mk(1,1,1,1,1, 96'hBAD, 16'h1234, 0, 96'h0,  16'h0000, 0, 0));
    tab1.push_back(mk(0,0,0,0,1, 96'hA5,  16'h00FF, 1, 96'hA5, 16'h00FF, 0, 0));
    tab1.push_back(mk(0,0,0,1,1, 96'h77,  16'h0101, 0, 96'hA5, 16'h0000, 1, 0));
    tab1.push_back(mk(0,0,0,0,1, 96'h5A,  16'h0F0F, 1, 96'h5A, 16'h0F0F, 1, 0));
    for (int i = 0; i < 3; i++)
      tab1.push_back(mk(0,0,1,1,1, 96'h99, 16'h3333, 1, 96'h5A, 16'h0F0F, 1, 0));
    tab1.push_back(mk(0,0,0,0,0, 96'h66,  16'h0C0C, 0, 96'h66, 16'h0C0C, 1, 0));
    tab1.push_back(mk(0,1,0,1,1, 96'h44,  16'h4444, 0, 96'h66, 16'h0000, 1, 1));
    tab1.push_back(mk(0,1,1,0,1, 96'h45,  16'h4545, 0, 96'h66, 16'h0000, 1, 2));
    tab1.push_back(mk(1,0,0,0,1, 96'h46,  16'h4646, 0, 96'h0,  16'h0000, 0, 0));
    for (int i = 1; i <= 5; i++)
      tab1.push_back(mk(0,0,0,1,1, 96'h10, 16'h0010, 0, 96'h0, 16'h0000,
                        16'((i > 3) ? 3 : i), 0));
    for (int i = 1; i <= 4; i++)
      tab1.push_back(mk(0,1,0,0,1, 96'h20, 16'h0020, 0, 96'h0, 16'h0000, 3,
                        16'((i > 3) ? 3 : i)));

    // DEPTH=3, NOP=0xDEAD: stream latency, flush+hold drain, bubble in slot 0
    tab3.push_back(mk(1,1,0,1,1, 96'hBAD, 16'h1234, 0, 96'h0,  NOP3, 0, 0));
    tab3.push_back(mk(1,0,1,0,1, 96'hBAD, 16'h1234, 0, 96'h0,  NOP3, 0, 0));
    tab3.push_back(mk(0,0,0,0,1, 96'h11,  16'h0001, 0, 96'h0,  NOP3, 0, 0));
    tab3.push_back(mk(0,0,0,0,1, 96'h22,  16'h0002, 0, 96'h0,  NOP3, 0, 0));
    tab3.push_back(mk(0,0,0,0,1, 96'h33,  16'h0003, 1, 96'h11, 16'h0001, 0, 0));
    tab3.push_back(mk(0,0,0,0,1, 96'h44,  16'h0004, 1, 96'h22, 16'h0002, 0, 0));
    tab3.push_back(mk(0,0,0,0,1, 96'h55,  16'h0005, 1, 96'h33, 16'h0003, 0, 0));
    tab3.push_back(mk(0,1,1,0,1, 96'h66,  16'h0006, 0, 96'h33, NOP3, 0, 1));
    tab3.push_back(mk(0,0,0,0,0, 96'h0,   16'h0000, 0, 96'h44, NOP3, 0, 1));
    tab3.push_back(mk(0,0,0,0,0, 96'h0,   16'h0000, 0, 96'h55, NOP3, 0, 1));
    tab3.push_back(mk(0,0,0,0,0, 96'h0,   16'h0000, 0, 96'h0,  16'h0000, 0, 1));
    tab3.push_back(mk(0,0,0,0,1, 96'h71,  16'h0071, 0, 96'h0,  16'h0000, 0, 1));
    tab3.push_back(mk(0,0,0,0,1, 96'h72,  16'h0072, 0, 96'h0,  16'h0000, 0, 1));
    tab3.push_back(mk(0,0,0,1,1, 96'h99,  16'h0099, 1, 96'h71, 16'h0071, 1, 1));
    tab3.push_back(mk(0,0,0,0,1, 96'h73,  16'h0073, 1, 96'h72, 16'h0072, 1, 1));
    tab3.push_back(mk(0,0,0,0,1, 96'h74,  16'h0074, 0, 96'h72, NOP3, 1, 1));
    tab3.push_back(mk(0,0,0,0,1, 96'h75,  16'h0075, 1, 96'h73, 16'h0073, 1, 1));

    foreach (tab1[i]) begin
      apply(tab1[i]);
      $display("d1 row %0d: valid=%0b data=0x%0h ctrl=0x%0h bcnt=%0d fcnt=%0d",
               i, d1_valid, d1_data, d1_ctrl, d1_bcnt, d1_fcnt);
      chk("d1_valid", i, DW'(d1_valid), DW'(tab1[i].ev));
      chk("d1_data",  i, d1_data,       tab1[i].ed);
      chk("d1_ctrl",  i, DW'(d1_ctrl),  DW'(tab1[i].ec));
      chk("d1_bcnt",  i, DW'(d1_bcnt),  DW'(tab1[i].eb));
      chk("d1_fcnt",  i, DW'(d1_fcnt),  DW'(tab1[i].ef));
    end

    foreach (tab3[i]) begin
      apply(tab3[i]);
      $display("d3 row %0d: valid=%0b data=0x%0h ctrl=0x%0h bcnt=%0d fcnt=%0d",
               i, d3_valid, d3_data, d3_ctrl, d3_bcnt, d3_fcnt);
      chk("d3_valid", i, DW'(d3_valid), DW'(tab3[i].ev));
      chk("d3_data",  i, d3_data,       tab3[i].ed);
      chk("d3_ctrl",  i, DW'(d3_ctrl),  DW'(tab3[i].ec));
      chk("d3_bcnt",  i, DW'(d3_bcnt),  DW'(tab3[i].eb));
      chk("d3_fcnt",  i, DW'(d3_fcnt),  DW'(tab3[i].ef));
    end

    // Reset mid-stream: the in-flight 0x73..0x75 items vanish on the reset edge
    apply(mk(1,0,0,0,1, 96'h76, 16'h0076, 0, 96'h0, NOP3, 0, 0));
    $display("d3 midreset: valid=%0b data=0x%0h ctrl=0x%0h bcnt=%0d fcnt=%0d",
             d3_valid, d3_data, d3_ctrl, d3_bcnt, d3_fcnt);
    chk("midrst_valid", 0, DW'(d3_valid), DW'(1'b0));
    chk("midrst_data",  0, d3_data,       DW'(0));
    chk("midrst_ctrl",  0, DW'(d3_ctrl),  DW'(NOP3));
    chk("midrst_bcnt",  0, DW'(d3_bcnt),  DW'(0));
    chk("midrst_fcnt",  0, DW'(d3_fcnt),  DW'(0));
    apply(mk(0,0,0,0,1, 96'h77, 16'h0077, 0, 96'h0, NOP3, 0, 0));
    $display("d3 postreset: valid=%0b data=0x%0h ctrl=0x%0h",
             d3_valid, d3_data, d3_ctrl);
    chk("postrst_valid", 1, DW'(d3_valid), DW'(1'b0));
    chk("postrst_data",  1, d3_data,       DW'(0));
    chk("postrst_ctrl",  1, DW'(d3_ctrl),  DW'(NOP3));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
